// File: rtl/hdlc_chk_pkg.sv
// Shared definitions for the HDLC receive-side protocol checker:
// check IDs, bit patterns, tracker states and a small popcount helper.
package hdlc_chk_pkg;

    localparam int NUM_CHK = 7;
    localparam logic [7:0] FLAG_PAT  = 8'h7E;
    localparam logic [7:0] ABORT_PAT = 8'h7F;

    typedef enum logic [2:0] {
        CHK_FLAG_MISS  = 3'd0,
        CHK_FLAG_SPUR  = 3'd1,
        CHK_ABORT_MISS = 3'd2,
        CHK_ABORT_SIG  = 3'd3,
        CHK_EOF_MISS   = 3'd4,
        CHK_OVF_MISS   = 3'd5,
        CHK_OVF_SPUR   = 3'd6
    } chk_id_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_OVF   = 2'd2
    } trk_state_e;

    function automatic logic [3:0] popcount(input logic [NUM_CHK-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_CHK; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/hdlc_rx_protocol_checker_if.sv
// Snooped Rx-block signals plus checker control/status, bundled for the checker.
interface hdlc_rx_protocol_checker_if #(parameter int ERR_CNT_W = 16);
    import hdlc_chk_pkg::*;

    logic                 Rx;
    logic                 Rx_FlagDetect;
    logic                 Rx_AbortDetect;
    logic                 Rx_ValidFrame;
    logic                 Rx_AbortSignal;
    logic                 Rx_EoF;
    logic                 Rx_NewByte;
    logic                 Rx_Overflow;
    logic [NUM_CHK-1:0]   ChkEn;
    logic                 ClrErr;
    logic [NUM_CHK-1:0]   ErrPulse;
    logic [NUM_CHK-1:0]   ErrSticky;
    logic [ERR_CNT_W-1:0] ErrCnt;

    modport master (
        output Rx, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal,
        output Rx_EoF, Rx_NewByte, Rx_Overflow, ChkEn, ClrErr,
        input  ErrPulse, ErrSticky, ErrCnt
    );

    modport slave (
        input  Rx, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal,
        input  Rx_EoF, Rx_NewByte, Rx_Overflow, ChkEn, ClrErr,
        output ErrPulse, ErrSticky, ErrCnt
    );

endinterface

// File: rtl/hdlc_expect_pipe.sv
// Delays a pattern-hit bit by LAT cycles so it lines up with the strobe
// the Rx block is expected to raise.
module hdlc_expect_pipe #(
    parameter int LAT = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_hit,
    output logic o_exp
);

    logic [LAT-1:0] r_pipe;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_hit;
            for (int i = 1; i < LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_exp = r_pipe[LAT-1];

endmodule

// File: rtl/hdlc_rx_protocol_checker.sv
// HDLC receive-side protocol checker: snoops Rx and the receiver strobes and
// reports per-check error pulses, sticky flags and a saturating error count.
//
// state    | meaning
// ST_IDLE  | no frame open; waiting for an opening flag
// ST_COUNT | frame open; counting Rx_NewByte strobes
// ST_OVF   | byte MAX_FRAME_BYTES+1 seen; counting stopped until frame ends
module hdlc_rx_protocol_checker
    import hdlc_chk_pkg::*;
#(
    parameter int FLAG_LAT        = 2,
    parameter int ABORT_LAT       = 2,
    parameter int MAX_FRAME_BYTES = 128,
    parameter int ERR_CNT_W       = 16
) (
    input logic                  Clk,
    input logic                  Rst,
    hdlc_rx_protocol_checker_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 2);
    localparam logic [CNT_W-1:0]     MAX_CNT     = CNT_W'(MAX_FRAME_BYTES);
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    logic [6:0]           r_sh;
    logic [7:0]           w_win;
    logic                 w_flag_hit;
    logic                 w_abort_hit;
    logic                 w_flag_exp;
    logic                 w_abort_exp;
    logic                 r_vf_d;
    logic                 r_ovf_d;
    logic                 r_abort_pend;
    logic                 r_eof_pend;
    logic                 r_ovf_pend;
    trk_state_e           r_state;
    trk_state_e           w_state_nxt;
    logic [CNT_W-1:0]     r_byte_cnt;
    logic [CNT_W-1:0]     w_byte_cnt_nxt;
    logic                 w_ovf_hit;
    logic [NUM_CHK-1:0]   w_err;
    logic [NUM_CHK-1:0]   w_err_m;
    logic [NUM_CHK-1:0]   r_err_pulse;
    logic [NUM_CHK-1:0]   r_err_sticky;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [ERR_CNT_W-1:0] w_cnt_base;
    logic [ERR_CNT_W-1:0] w_err_cnt_nxt;
    logic [ERR_CNT_W+3:0] w_sum;

    // Only the 7 previous bits are stored; the current Rx completes the window.
    assign w_win       = {r_sh, bus.Rx};
    assign w_flag_hit  = (w_win == FLAG_PAT);
    assign w_abort_hit = (w_win == ABORT_PAT);

    hdlc_expect_pipe #(.LAT(FLAG_LAT)) u_flag_pipe (
        .Clk   (Clk),
        .Rst   (Rst),
        .i_hit (w_flag_hit),
        .o_exp (w_flag_exp)
    );

    hdlc_expect_pipe #(.LAT(ABORT_LAT)) u_abort_pipe (
        .Clk   (Clk),
        .Rst   (Rst),
        .i_hit (w_abort_hit),
        .o_exp (w_abort_exp)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_ovf_hit      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.Rx_FlagDetect && !bus.Rx_ValidFrame) begin
                    w_state_nxt    = ST_COUNT;
                    w_byte_cnt_nxt = '0;
                end
            end
            ST_COUNT: begin
                // A closing flag or abort wins over a byte strobe in the same cycle.
                if (bus.Rx_FlagDetect || bus.Rx_AbortDetect) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.Rx_NewByte) begin
                    w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
                    if (r_byte_cnt == MAX_CNT) begin
                        w_ovf_hit   = 1'b1;
                        w_state_nxt = ST_OVF;
                    end
                end
            end
            ST_OVF: begin
                if (bus.Rx_FlagDetect || bus.Rx_AbortDetect) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_err = '0;
        w_err[CHK_FLAG_MISS]  = w_flag_exp & ~bus.Rx_FlagDetect;
        w_err[CHK_FLAG_SPUR]  = bus.Rx_FlagDetect & ~w_flag_exp;
        w_err[CHK_ABORT_MISS] = w_abort_exp & ~bus.Rx_AbortDetect;
        w_err[CHK_ABORT_SIG]  = r_abort_pend & ~bus.Rx_AbortSignal;
        w_err[CHK_EOF_MISS]   = r_eof_pend & ~bus.Rx_EoF;
        w_err[CHK_OVF_MISS]   = r_ovf_pend & ~bus.Rx_Overflow;
        w_err[CHK_OVF_SPUR]   = bus.Rx_Overflow & ~r_ovf_d &
                                ((r_state == ST_IDLE) ||
                                 ((r_state == ST_COUNT) && (r_byte_cnt <= MAX_CNT)));
        w_err_m = w_err & bus.ChkEn;

        // Clear first, then add this cycle's pulses, saturating at all-ones.
        w_cnt_base    = bus.ClrErr ? '0 : r_err_cnt;
        w_sum         = {4'b0000, w_cnt_base} + {{ERR_CNT_W{1'b0}}, popcount(w_err_m)};
        w_err_cnt_nxt = (|w_sum[ERR_CNT_W+3:ERR_CNT_W]) ? ERR_CNT_MAX : w_sum[ERR_CNT_W-1:0];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sh         <= '1;
            r_vf_d       <= 1'b0;
            r_ovf_d      <= 1'b0;
            r_abort_pend <= 1'b0;
            r_eof_pend   <= 1'b0;
            r_ovf_pend   <= 1'b0;
            r_state      <= ST_IDLE;
            r_byte_cnt   <= '0;
            r_err_pulse  <= '0;
            r_err_sticky <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_sh         <= w_win[6:0];
            r_vf_d       <= bus.Rx_ValidFrame;
            r_ovf_d      <= bus.Rx_Overflow;
            r_abort_pend <= bus.Rx_AbortDetect & bus.Rx_ValidFrame;
            r_eof_pend   <= r_vf_d & ~bus.Rx_ValidFrame;
            r_ovf_pend   <= w_ovf_hit;
            r_state      <= w_state_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_err_pulse  <= w_err_m;
            r_err_sticky <= (bus.ClrErr ? '0 : r_err_sticky) | w_err_m;
            r_err_cnt    <= w_err_cnt_nxt;
        end
    end

    assign bus.ErrPulse  = r_err_pulse;
    assign bus.ErrSticky = r_err_sticky;
    assign bus.ErrCnt    = r_err_cnt;

endmodule

// File: tb/tb_hdlc_rx_protocol_checker.sv
// Bench for hdlc_rx_protocol_checker: per-cycle vectors carry the expected
// ErrPulse; a scoreboard queue carries pulse/sticky/count expectations.
module tb_hdlc_rx_protocol_checker;

    localparam int W       = 8;
    localparam int CNT_MAX = (1 << W) - 1;

    localparam logic [9:0] I_RST = 10'h200;
    localparam logic [9:0] I_RX  = 10'h100;
    localparam logic [9:0] I_FD  = 10'h080;
    localparam logic [9:0] I_AD  = 10'h040;
    localparam logic [9:0] I_VF  = 10'h020;
    localparam logic [9:0] I_AS  = 10'h010;
    localparam logic [9:0] I_EOF = 10'h008;
    localparam logic [9:0] I_NB  = 10'h004;
    localparam logic [9:0] I_OVF = 10'h002;
    localparam logic [9:0] I_CLR = 10'h001;

    localparam logic [6:0] EN_ALL = 7'h7F;
    localparam logic [6:0] EN_NA  = 7'h7B;
    localparam logic [6:0] EN_NE  = 7'h6F;
    localparam logic [6:0] EN_OV  = 7'h60;

    typedef struct packed {
        logic [9:0] ins;
        logic [6:0] en;
        logic [6:0] want;
    } vec_t;

    typedef struct {
        logic [6:0]   pulse;
        logic [6:0]   sticky;
        logic [W-1:0] cnt;
        int           id;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst;
    int   checks = 0;
    int   failures = 0;
    int   vec_no = 0;
    int   m_sticky = 0;
    int   m_cnt = 0;
    vec_t tbl[$];
    exp_t sb[$];

    hdlc_rx_protocol_checker_if #(.ERR_CNT_W(W)) bus ();

    hdlc_rx_protocol_checker #(
        .FLAG_LAT(2), .ABORT_LAT(2), .MAX_FRAME_BYTES(128), .ERR_CNT_W(W)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic [9:0] ins, input logic [6:0] en,
                                input logic [6:0] want);
        vec_t v;
        v.ins  = ins;
        v.en   = en;
        v.want = want;
        return v;
    endfunction

    task automatic add(input logic [9:0] ins, input logic [6:0] en,
                       input logic [6:0] want, input int n);
        for (int i = 0; i < n; i++) tbl.push_back(mk(ins, en, want));
    endtask

    task automatic add_pat(input logic [7:0] pat, input logic [9:0] extra,
                           input logic [6:0] en);
        for (int b = 7; b >= 0; b--) add((pat[b] ? I_RX : 10'h000) | extra, en, 7'h00, 1);
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        int   s;
        @(negedge Clk);
        Rst                = v.ins[9];
        bus.Rx             = v.ins[8];
        bus.Rx_FlagDetect  = v.ins[7];
        bus.Rx_AbortDetect = v.ins[6];
        bus.Rx_ValidFrame  = v.ins[5];
        bus.Rx_AbortSignal = v.ins[4];
        bus.Rx_EoF         = v.ins[3];
        bus.Rx_NewByte     = v.ins[2];
        bus.Rx_Overflow    = v.ins[1];
        bus.ClrErr         = v.ins[0];
        bus.ChkEn          = v.en;
        if (v.ins[9]) begin
            m_sticky = 0;
            m_cnt    = 0;
        end else begin
            m_sticky = (v.ins[0] ? 0 : m_sticky) | int'(v.want);
            s        = (v.ins[0] ? 0 : m_cnt) + $countones(v.want);
            m_cnt    = (s > CNT_MAX) ? CNT_MAX : s;
        end
        e.pulse  = v.want;
        e.sticky = 7'(m_sticky);
        e.cnt    = W'(m_cnt);
        e.id     = vec_no;
        vec_no++;
        sb.push_back(e);
    endtask

    task automatic drive_pat(input logic [7:0] pat, input logic [9:0] extra,
                             input logic [6:0] en);
        for (int b = 7; b >= 0; b--) drive(mk((pat[b] ? I_RX : 10'h000) | extra, en, 7'h00));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.ErrPulse !== e.pulse) begin
                    failures++;
                    $display("FAIL pulse vec=%0d got=%h want=%h", e.id, bus.ErrPulse, e.pulse);
                end
                checks++;
                if (bus.ErrSticky !== e.sticky) begin
                    failures++;
                    $display("FAIL sticky vec=%0d got=%h want=%h", e.id, bus.ErrSticky, e.sticky);
                end
                checks++;
                if (bus.ErrCnt !== e.cnt) begin
                    failures++;
                    $display("FAIL errcnt vec=%0d got=%0d want=%0d", e.id, bus.ErrCnt, e.cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : driver
        Rst = 1'b1;
        bus.Rx = 1'b1;
        bus.Rx_FlagDetect = 1'b0;
        bus.Rx_AbortDetect = 1'b0;
        bus.Rx_ValidFrame = 1'b0;
        bus.Rx_AbortSignal = 1'b0;
        bus.Rx_EoF = 1'b0;
        bus.Rx_NewByte = 1'b0;
        bus.Rx_Overflow = 1'b0;
        bus.ClrErr = 1'b0;
        bus.ChkEn = EN_ALL;

        // Reset, then flag detected on time, then flag withheld.
        add(I_RST | I_RX, EN_ALL, 7'h00, 2);
        add(I_RX, EN_NA, 7'h00, 2);
        add_pat(8'h7E, 10'h000, EN_NA);
        add(I_RX, EN_NA, 7'h00, 1);
        add(I_RX | I_FD, EN_NA, 7'h00, 1);
        add(I_RX, EN_NA, 7'h00, 10);
        add_pat(8'h7E, 10'h000, EN_NA);
        add(I_RX, EN_NA, 7'h00, 1);
        add(I_RX, EN_NA, 7'h01, 1);
        add(I_RX, EN_NA, 7'h00, 10);
        // Spurious flag, sticky hold, clear together with a new pulse, plain clear.
        add(I_RX | I_FD, EN_NA, 7'h02, 1);
        add(I_RX, EN_NA, 7'h00, 2);
        add(I_RX | I_FD | I_CLR, EN_NA, 7'h02, 1);
        add(I_RX, EN_NA, 7'h00, 1);
        add(I_RX | I_CLR, EN_NA, 7'h00, 1);
        add(I_RX, EN_NA, 7'h00, 1);
        // Abort signalling missing, then present.
        add(I_RX | I_AD | I_VF, EN_ALL, 7'h00, 1);
        add(I_RX, EN_ALL, 7'h08, 1);
        add(I_RX | I_EOF, EN_ALL, 7'h00, 1);
        add(I_RX | I_AD | I_VF, EN_ALL, 7'h00, 1);
        add(I_RX | I_AS, EN_ALL, 7'h00, 1);
        add(I_RX | I_EOF, EN_ALL, 7'h00, 1);
        // Abort pattern without strobe, then with strobe.
        add_pat(8'h7F, 10'h000, EN_ALL);
        add(I_RX, EN_ALL, 7'h00, 1);
        add(I_RX, EN_ALL, 7'h04, 1);
        add(I_RX, EN_ALL, 7'h00, 2);
        add_pat(8'h7F, 10'h000, EN_ALL);
        add(I_RX, EN_ALL, 7'h00, 1);
        add(I_RX | I_AD, EN_ALL, 7'h00, 1);
        add(I_RX, EN_ALL, 7'h00, 2);
        // End of frame: masked miss, enabled miss, then a proper EoF.
        add(I_RX | I_VF, EN_NE, 7'h00, 2);
        add(I_RX, EN_NE, 7'h00, 3);
        add(I_RX | I_VF, EN_ALL, 7'h00, 2);
        add(I_RX, EN_ALL, 7'h00, 1);
        add(I_RX, EN_ALL, 7'h10, 1);
        add(I_RX, EN_ALL, 7'h00, 1);
        add(I_RX | I_VF, EN_ALL, 7'h00, 1);
        add(I_RX, EN_ALL, 7'h00, 1);
        add(I_RX | I_EOF, EN_ALL, 7'h00, 1);

        for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

        // Frame length: 128 bytes legal, byte 129 without overflow, spurious overflow.
        drive(mk(I_RST | I_RX, EN_ALL, 7'h00));
        drive(mk(I_RX | I_FD, EN_OV, 7'h00));
        for (int i = 0; i < 128; i++) drive(mk(I_RX | I_NB, EN_OV, 7'h00));
        drive(mk(I_RX, EN_OV, 7'h00));
        drive(mk(I_RX | I_NB, EN_OV, 7'h00));
        drive(mk(I_RX, EN_OV, 7'h20));
        drive(mk(I_RX | I_OVF, EN_OV, 7'h00));
        drive(mk(I_RX, EN_OV, 7'h00));
        drive(mk(I_RX | I_FD, EN_OV, 7'h00));
        drive(mk(I_RX | I_FD, EN_OV, 7'h00));
        for (int i = 0; i < 10; i++) drive(mk(I_RX | I_NB, EN_OV, 7'h00));
        drive(mk(I_RX | I_OVF, EN_OV, 7'h40));
        drive(mk(I_RX | I_OVF, EN_OV, 7'h00));
        drive(mk(I_RX, EN_OV, 7'h00));
        drive(mk(I_RX | I_FD, EN_OV, 7'h00));
        drive(mk(I_RX | I_OVF, EN_OV, 7'h40));
        drive(mk(I_RX, EN_OV, 7'h00));

        // Counter saturation with two simultaneous errors.
        drive(mk(I_RST | I_RX, EN_ALL, 7'h00));
        for (int i = 0; i < CNT_MAX - 1; i++) drive(mk(I_RX | I_FD, 7'h02, 7'h02));
        drive_pat(8'h7E, I_VF, 7'h11);
        drive(mk(I_RX, 7'h11, 7'h00));
        drive(mk(I_RX, 7'h11, 7'h11));
        drive(mk(I_RX, 7'h11, 7'h00));

        // Reset mid-frame while a flag expectation is in flight.
        for (int i = 0; i < 10; i++) drive(mk(I_RX, EN_NA, 7'h00));
        drive_pat(8'h7E, I_VF, EN_NA);
        drive(mk(I_RST | I_RX | I_VF, EN_NA, 7'h00));
        for (int i = 0; i < 4; i++) drive(mk(I_RX, EN_NA, 7'h00));

        @(posedge Clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
